// File: rtl/timer_dev.sv
// timer_dev: programmable countdown timer on the CPU data bus with a level irq to CP0.
// Registers: addr 0 CTRL {IM, MODE[1:0], EN}, addr 1 PRESET, addr 2 COUNT (read-only), addr 3 reserved.
// Optional feature macro: TIMER_PRESCALE_EN (slows the count rate by PRESCALE_DIV).
module timer_dev #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_en;
  logic               w_en_nxt;
  logic [1:0]         r_mode;
  logic [1:0]         w_mode_nxt;
  logic               r_im;
  logic               w_im_nxt;
  logic [WIDTH-1:0]   r_preset;
  logic [WIDTH-1:0]   w_preset_nxt;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count_nxt;
  logic               r_pending;
  logic               w_pending_nxt;

  logic               w_ctrl_wr;
  logic               w_preset_wr;
  logic               w_step;

  // Bus write decode.
  assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
  assign w_preset_wr = we && (addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PSC_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

  logic [PSC_W-1:0]   r_psc;
  logic [PSC_W-1:0]   w_psc_nxt;

  // A count step happens only on the last prescaler phase.
  assign w_step = (r_psc == PSC_W'(PRESCALE_DIV - 1));
`else
  logic               w_unused_div;

  // Without the prescaler every CNT cycle is a count step.
  assign w_step       = 1'b1;
  assign w_unused_div = ^PRESCALE_DIV;
`endif

  // State and register file, synchronous reset wins over any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_en      <= 1'b0;
      r_mode    <= 2'b00;
      r_im      <= 1'b0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      r_psc     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_en      <= w_en_nxt;
      r_mode    <= w_mode_nxt;
      r_im      <= w_im_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
`ifdef TIMER_PRESCALE_EN
      r_psc     <= w_psc_nxt;
`endif
    end
  end

  // Next-state and next-register logic; bus CTRL writes are applied last so they win.
  always_comb begin
    w_state_nxt   = r_state;
    w_en_nxt      = r_en;
    w_mode_nxt    = r_mode;
    w_im_nxt      = r_im;
    w_preset_nxt  = r_preset;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;
`ifdef TIMER_PRESCALE_EN
    w_psc_nxt     = r_psc;
`endif

    if (w_preset_wr) begin
      w_preset_nxt = WIDTH'(wdata);
    end

    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        w_count_nxt = r_preset;
`ifdef TIMER_PRESCALE_EN
        w_psc_nxt   = '0;
`endif
        w_state_nxt = S_CNT;
      end

      S_CNT: begin
        if (!r_en) begin
          // Pause: COUNT and prescaler hold; re-enable reloads from PRESET.
          w_state_nxt = S_IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          w_psc_nxt = w_step ? '0 : (r_psc + PSC_W'(1));
`endif
          if (w_step) begin
            if (r_count <= WIDTH'(1)) begin
              if (w_ctrl_wr && !wdata[0]) begin
                // A disabling CTRL write on the expiry edge cancels the expiry.
                w_state_nxt = S_IDLE;
              end else begin
                w_count_nxt   = '0;
                w_pending_nxt = 1'b1;
                w_state_nxt   = S_INT;
              end
            end else begin
              w_count_nxt = r_count - WIDTH'(1);
            end
          end
        end
      end

      S_INT: begin
        if (r_mode == MODE_RELOAD) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_LOAD;
        end else begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_ctrl_wr) begin
      w_en_nxt      = wdata[0];
      w_mode_nxt    = wdata[2:1];
      w_im_nxt      = wdata[3];
      w_pending_nxt = 1'b0;
    end
  end

  // Read mux, combinational from addr.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
      ADDR_PRESET: rdata = 32'(r_preset);
      ADDR_COUNT:  rdata = 32'(r_count);
      default:     rdata = 32'd0;
    endcase
  end

  // Interrupt level from registered state only.
  assign irq = r_pending & r_im;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev with a timestamp-based reference model.
module tb_timer_dev;

`ifdef TIMER_PRESCALE_EN
  localparam longint DIV = 4;
`else
  localparam longint DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  addr;
    longint      cyc;
  } exp_t;

  exp_t exp_q[$];

  timer_dev #(.WIDTH(32), .PRESCALE_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: programmer-visible registers plus a schedule of load/expiry/int edges.
  bit          m_en;
  logic [1:0]  m_mode;
  bit          m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_pending;
  longint      t_now;
  longint      t_load;
  longint      t_int;
  bit          seg_on;
  longint      seg_start;
  longint      seg_exp;
  logic [31:0] seg_p;

  task automatic model_reset();
    m_en = 0; m_mode = 2'b00; m_im = 0; m_preset = 0; m_count = 0; m_pending = 0;
    t_load = -1; t_int = -1; seg_on = 0; seg_start = 0; seg_exp = 0; seg_p = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge with that cycle's bus inputs.
  task automatic model_step(input bit r_i, input bit w_i, input logic [1:0] a_i, input logic [31:0] d_i);
    bit cw;
    longint span;
    cw = w_i && (a_i == 2'd0);
    t_now++;
    if (r_i) begin
      model_reset();
      return;
    end
    if (t_now == t_load) begin
      span      = (m_preset == 0) ? 1 : longint'(m_preset);
      seg_on    = 1;
      seg_start = t_now;
      seg_p     = m_preset;
      seg_exp   = t_now + span * DIV;
      m_count   = m_preset;
      t_load    = -1;
    end else if (seg_on) begin
      if (!m_en) begin
        seg_on = 0;
      end else if (t_now == seg_exp) begin
        seg_on = 0;
        if (!(cw && !d_i[0])) begin
          m_count   = 0;
          m_pending = 1;
          t_int     = t_now + 1;
        end
      end else begin
        m_count = seg_p - 32'((t_now - seg_start) / DIV);
      end
    end else if (t_now == t_int) begin
      t_int = -1;
      if (m_mode == 2'b01) begin
        m_pending = 0;
        t_load    = t_now + 1;
      end else begin
        m_en = 0;
      end
    end else if (m_en) begin
      t_load = t_now + 1;
    end
    if (cw) begin
      m_en = d_i[0]; m_mode = d_i[2:1]; m_im = d_i[3]; m_pending = 0;
    end
    if (w_i && (a_i == 2'd1)) m_preset = d_i;
  endtask

  // One bus cycle: drive inputs, queue the expected response, then cross the edge.
  task automatic cycle(input bit r_i, input bit w_i, input logic [1:0] a_i, input logic [31:0] d_i);
    exp_t e;
    rst = r_i; we = w_i; addr = a_i; wdata = d_i;
    e.rdata = model_read(a_i);
    e.irq   = m_pending & m_im;
    e.addr  = a_i;
    e.cyc   = t_now;
    exp_q.push_back(e);
    @(posedge clk);
    model_step(r_i, w_i, a_i, d_i);
    #1;
  endtask

  task automatic rd(input logic [1:0] a_i, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a_i, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a_i, input logic [31:0] d_i);
    cycle(1'b0, 1'b1, a_i, d_i);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0, 32'd0);
  endtask

  // Monitor: compare DUT outputs against the queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata cyc=%0d addr=%0d got=%h expected=%h", e.cyc, e.addr, rdata, e.rdata);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL irq cyc=%0d got=%b expected=%b", e.cyc, irq, e.irq);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized bus traffic.
  initial begin
    int unsigned k;
    logic [1:0]  a;
    logic [31:0] d;
    t_now = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state and ignored COUNT write.
    do_reset(3);
    rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 1);
    wr(2'd2, 32'h55);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, 1); rd(2'd3, 1);

    // One-shot with irq, then a CTRL write clears pending.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd2, 8);
    rd(2'd0, 4);
    wr(2'd0, 32'h8);
    rd(2'd0, 3);

    // Auto-reload pulses, then stop.
    do_reset(1);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd(2'd2, 20);
    wr(2'd0, 32'h2);
    rd(2'd2, 12);

    // Masked expiry, then unmask with a CTRL write.
    do_reset(1);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    rd(2'd2, 16);
    wr(2'd0, 32'h9);
    rd(2'd2, 6);

    // PRESET=0 behaves as 1.
    do_reset(1);
    wr(2'd0, 32'h9);
    rd(2'd2, 6);

    // CTRL write on the expiry edge wins.
    do_reset(1);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    rd(2'd2, 4 * int'(DIV) + 1);
    wr(2'd0, 32'h8);
    rd(2'd2, 3); rd(2'd0, 2);

    // Reset in the middle of a count.
    do_reset(1);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    rd(2'd2, 4);
    do_reset(1);
    rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 3);

    // Prescaled step spacing (single-step spacing when the prescaler is absent).
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    rd(2'd2, 14);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (k < 1) begin
        do_reset(1);
      end else if (k < 7) begin
        if (k < 5) d[0] = 1'b1;
        wr(2'd0, d);
      end else if (k < 11) begin
        wr(2'd1, 32'($urandom_range(0, 9)));
      end else if (k < 13) begin
        wr(2'($urandom_range(2, 3)), d);
      end else begin
        rd(a, 1);
      end
    end

    rd(2'd0, 2);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
